// File: rtl/timer_pkg.sv
// timer_pkg: constants and types shared by the timer counter, the register
// block and the wrap detector.
//   TIMER_WIDTH  default counter width
//   MISS_W_DEF   default width of the missed-event counter
//   CNT_MAX      all-ones count for the default width
//   CNT_MIN      zero count for the default width
//   wrap_evt_t   one-cycle wrap event pair (overflow / underflow)
package timer_pkg;

    localparam int TIMER_WIDTH = 8;
    localparam int MISS_W_DEF  = 4;

    localparam logic [TIMER_WIDTH-1:0] CNT_MAX = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] CNT_MIN = '0;

    typedef struct packed {
        logic ovf;
        logic udf;
    } wrap_evt_t;

endpackage

// File: rtl/timer_wrap_cmp.sv
// timer_wrap_cmp: combinational wrap classifier.
// Ports:
//   cnt      in   WIDTH  current count
//   last_cnt in   WIDTH  count one pclk earlier
//   load_d   in   1      load strobe aligned with the cnt/last_cnt pair
//   updown_d in   1      direction aligned with the cnt/last_cnt pair (1 = down)
//   evt      out  2      {ovf, udf} wrap events for this cycle
module timer_wrap_cmp
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] last_cnt,
    input  logic             load_d,
    input  logic             updown_d,
    output wrap_evt_t        evt
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN = '0;

    // A loaded value is never a wrap, even when it lands on MAX->MIN or
    // MIN->MAX. A held count has cnt == last_cnt and can never match.
    always_comb begin
        evt     = '0;
        evt.ovf = !load_d && !updown_d && (last_cnt == MAX) && (cnt == MIN);
        evt.udf = !load_d &&  updown_d && (last_cnt == MIN) && (cnt == MAX);
    end

endmodule

// File: rtl/timer_wrap_detect.sv
// timer_wrap_detect: sticky overflow/underflow flags and one maskable irq,
// driven by the counter's cnt/last_cnt pair.
// Optional feature: define MISS_CNT_EN to count wrap events that arrive
// while the matching flag is still set (saturating, cleared by any clr).
// Ports:
//   pclk      in   1       clock, all state on posedge
//   preset_n  in   1       asynchronous active-low reset
//   cnt       in   WIDTH   current count
//   last_cnt  in   WIDTH   count one pclk earlier
//   load      in   1       counter load strobe
//   updown    in   1       direction, 1 = down
//   clr_ovf   in   1       W1C clear of ovf_flag
//   clr_udf   in   1       W1C clear of udf_flag
//   ovf_ie    in   1       overflow interrupt enable
//   udf_ie    in   1       underflow interrupt enable
//   ovf_flag  out  1       sticky overflow status
//   udf_flag  out  1       sticky underflow status
//   irq       out  1       registered interrupt request (level)
//   miss_cnt  out  MISS_W  lost events (zero unless MISS_CNT_EN)
module timer_wrap_detect
    import timer_pkg::*;
#(
    parameter int WIDTH  = TIMER_WIDTH,
    parameter int MISS_W = MISS_W_DEF
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [WIDTH-1:0]  cnt,
    input  logic [WIDTH-1:0]  last_cnt,
    input  logic              load,
    input  logic              updown,
    input  logic              clr_ovf,
    input  logic              clr_udf,
    input  logic              ovf_ie,
    input  logic              udf_ie,
    output logic              ovf_flag,
    output logic              udf_flag,
    output logic              irq,
    output logic [MISS_W-1:0] miss_cnt
);

    logic      load_d;
    logic      updown_d;
    wrap_evt_t evt;

    // The counter applies load/updown at the same edge we sample them, so
    // the registered copies line up with the resulting cnt/last_cnt pair.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            load_d   <= 1'b0;
            updown_d <= 1'b0;
        end else begin
            load_d   <= load;
            updown_d <= updown;
        end
    end

    timer_wrap_cmp #(.WIDTH(WIDTH)) u_cmp (
        .cnt      (cnt),
        .last_cnt (last_cnt),
        .load_d   (load_d),
        .updown_d (updown_d),
        .evt      (evt)
    );

    // A new event wins over a clear in the same cycle so it is never lost.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (evt.ovf)     ovf_flag <= 1'b1;
            else if (clr_ovf) ovf_flag <= 1'b0;
            if (evt.udf)     udf_flag <= 1'b1;
            else if (clr_udf) udf_flag <= 1'b0;
        end
    end

    // irq follows the registered flags, adding one cycle after the flag.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) irq <= 1'b0;
        else           irq <= (ovf_flag & ovf_ie) | (udf_flag & udf_ie);
    end

`ifdef MISS_CNT_EN
    logic [MISS_W-1:0] miss_q;
    logic              miss_hit;

    assign miss_hit = (evt.ovf & ovf_flag & ~clr_ovf) |
                      (evt.udf & udf_flag & ~clr_udf);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)
            miss_q <= '0;
        else if (clr_ovf | clr_udf)
            miss_q <= '0;
        else if (miss_hit && (miss_q != {MISS_W{1'b1}}))
            miss_q <= miss_q + 1'b1;
    end

    assign miss_cnt = miss_q;
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_timer_wrap_detect.sv
module tb_timer_wrap_detect;
    import timer_pkg::*;

`ifdef MISS_CNT_EN
    localparam bit MISS_ON = 1'b1;
`else
    localparam bit MISS_ON = 1'b0;
`endif

    localparam int HOLD = 0, UP = 1, DN = 2, LD = 3;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic [7:0] cnt, last_cnt;
    logic       load, updown, clr_ovf, clr_udf, ovf_ie, udf_ie;
    logic       ovf_flag, udf_flag, irq;
    logic [3:0] miss_cnt;

    timer_wrap_detect dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .cnt      (cnt),
        .last_cnt (last_cnt),
        .load     (load),
        .updown   (updown),
        .clr_ovf  (clr_ovf),
        .clr_udf  (clr_udf),
        .ovf_ie   (ovf_ie),
        .udf_ie   (udf_ie),
        .ovf_flag (ovf_flag),
        .udf_flag (udf_flag),
        .irq      (irq),
        .miss_cnt (miss_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic       o;
        logic       u;
        logic       i;
        logic [3:0] m;
    } exp_t;

    exp_t q[$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    bit   chk_en    = 1'b0;

    // behavioural model: counter value + the action it is about to take,
    // plus the status the block should present
    logic [7:0] cur;
    int         cur_act;
    logic [7:0] cur_tdr;
    logic       p_ovf, p_udf;
    logic       m_ovf, m_udf, m_irq;
    logic [3:0] m_miss;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur = 8'h00; cur_act = HOLD; cur_tdr = 8'h00;
        p_ovf = 1'b0; p_udf = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0; m_irq = 1'b0; m_miss = 4'h0;
        cnt = 8'h00; last_cnt = 8'h00;
        load = 1'b0; updown = 1'b0;
        clr_ovf = 1'b0; clr_udf = 1'b0; ovf_ie = 1'b0; udf_ie = 1'b0;
    endtask

    // One clock: account for the edge just taken, show the counter result
    // of the action taken at that edge, then present the next action.
    task automatic step(input int act, input logic [7:0] tdr, input logic dir,
                        input logic co, input logic cu, input logic io, input logic iu);
        logic irq_n;
        @(posedge pclk); #1;
        // status after this edge, from what was presented before it
        irq_n = (m_ovf & ovf_ie) | (m_udf & udf_ie);
        if (clr_ovf || clr_udf) m_miss = 4'h0;
        else if (((p_ovf && m_ovf) || (p_udf && m_udf)) && m_miss != 4'hF) m_miss = m_miss + 4'h1;
        if (p_ovf) m_ovf = 1'b1; else if (clr_ovf) m_ovf = 1'b0;
        if (p_udf) m_udf = 1'b1; else if (clr_udf) m_udf = 1'b0;
        m_irq = irq_n;
        if (chk_en) q.push_back('{m_ovf, m_udf, m_irq, MISS_ON ? m_miss : 4'h0});
        // counter moved at this edge; only a real count across the end wraps
        p_ovf = (cur_act == UP) && (cur == 8'hFF);
        p_udf = (cur_act == DN) && (cur == 8'h00);
        last_cnt = cur;
        case (cur_act)
            UP:      cur = cur + 8'h01;
            DN:      cur = cur - 8'h01;
            LD:      cur = cur_tdr;
            default: cur = cur;
        endcase
        cnt = cur;
        // next action
        cur_act = act; cur_tdr = tdr;
        load    = (act == LD);
        updown  = (act == UP) ? 1'b0 : (act == DN) ? 1'b1 : dir;
        clr_ovf = co; clr_udf = cu; ovf_ie = io; udf_ie = iu;
    endtask

    task automatic mid_reset();
        @(posedge pclk); #2;
        chk_en = 1'b0;
        q.delete();
        preset_n = 1'b0;
        #1;
        chk("rst_ovf_flag", {7'd0, ovf_flag}, 8'd0);
        chk("rst_udf_flag", {7'd0, udf_flag}, 8'd0);
        chk("rst_irq",      {7'd0, irq},      8'd0);
        chk("rst_miss_cnt", {4'd0, miss_cnt}, 8'd0);
        model_clear();
        @(negedge pclk);
        preset_n = 1'b1;
        chk_en = 1'b1;
    endtask

    // monitor: status is presented every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (chk_en && q.size() > 0) begin
                e = q.pop_front();
                chk("ovf_flag", {7'd0, ovf_flag}, {7'd0, e.o});
                chk("udf_flag", {7'd0, udf_flag}, {7'd0, e.u});
                chk("irq",      {7'd0, irq},      {7'd0, e.i});
                chk("miss_cnt", {4'd0, miss_cnt}, {4'd0, e.m});
            end
        end
    end

    initial begin
        logic [7:0] tdr;
        int         a;
        model_clear();
        preset_n = 1'b0;
        #3;
        chk("por_ovf_flag", {7'd0, ovf_flag}, 8'd0);
        chk("por_udf_flag", {7'd0, udf_flag}, 8'd0);
        chk("por_irq",      {7'd0, irq},      8'd0);
        chk("por_miss_cnt", {4'd0, miss_cnt}, 8'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        chk_en = 1'b1;

        // up count FC..00 with ovf_ie, irq one cycle after flag
        step(LD, 8'hFC, 1'b0, 0, 0, 1, 0);
        repeat (4) step(UP, 8'h00, 1'b0, 0, 0, 1, 0);
        repeat (4) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 0);
        step(HOLD, 8'h00, 1'b0, 1, 1, 1, 0);

        // down count 03 past 00, udf masked
        step(LD, 8'h03, 1'b1, 0, 0, 1, 0);
        repeat (5) step(DN, 8'h00, 1'b1, 0, 0, 1, 0);
        repeat (3) step(HOLD, 8'h00, 1'b1, 0, 0, 1, 0);
        step(HOLD, 8'h00, 1'b0, 1, 1, 1, 1);

        // loads that look like wraps
        step(LD, 8'hFF, 1'b0, 0, 0, 1, 1);
        step(LD, 8'h00, 1'b0, 0, 0, 1, 1);
        step(LD, 8'hFF, 1'b1, 0, 0, 1, 1);
        repeat (3) step(HOLD, 8'h00, 1'b1, 0, 0, 1, 1);

        // set beats clear: clr_ovf while the next wrap is visible
        step(LD, 8'hFF, 1'b0, 0, 0, 1, 1);
        step(UP, 8'h00, 1'b0, 0, 0, 1, 1);
        step(LD, 8'hFF, 1'b0, 0, 0, 1, 1);
        step(UP, 8'h00, 1'b0, 0, 0, 1, 1);
        step(HOLD, 8'h00, 1'b0, 1, 0, 1, 1);
        repeat (2) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 1);
        step(HOLD, 8'h00, 1'b0, 1, 1, 1, 1);

        // 20 overflows without clearing, then clear
        repeat (20) begin
            step(LD, 8'hFF, 1'b0, 0, 0, 1, 0);
            step(UP, 8'h00, 1'b0, 0, 0, 1, 0);
        end
        repeat (2) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 0);
        step(HOLD, 8'h00, 1'b0, 1, 0, 1, 0);
        repeat (2) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 0);

        // reset while flag and irq are up
        step(LD, 8'hFF, 1'b0, 0, 0, 1, 1);
        step(UP, 8'h00, 1'b0, 0, 0, 1, 1);
        repeat (3) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 1);
        mid_reset();
        repeat (4) step(HOLD, 8'h00, 1'b0, 0, 0, 1, 1);

        // random traffic biased towards the wrap points
        repeat (1500) begin
            a = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: tdr = 8'hFF;
                1: tdr = 8'h00;
                2: tdr = 8'hFD;
                3: tdr = 8'h02;
                default: tdr = 8'($urandom);
            endcase
            step(a, tdr, 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        step(HOLD, 8'h00, 1'b0, 0, 0, 0, 0);
        @(negedge pclk);
        @(negedge pclk);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
